// File: rtl/para_pkg.sv
// Shared constants and state type for the result-tile drain path.
// Holds tile geometry defaults, AXI encodings and the drain FSM enum.
package para_pkg;

    localparam int ROWS_DEF = 8;
    localparam int COLS_DEF = 8;
    localparam int DW_DEF   = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } drain_state_t;

endpackage

// File: rtl/out_tile_buf.sv
// Tile holding register: loads a whole ROWS x COLS x DW tile at once.
// Ports: clk, load, tile_in (packed tile), row_sel -> row_data (one row).
module out_tile_buf
    import para_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int DW   = DW_DEF,
    parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                             clk,
    input  logic                             load,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_in,
    input  logic [RW-1:0]                    row_sel,
    output logic [COLS*DW-1:0]               row_data
);

    logic [ROWS-1:0][COLS-1:0][DW-1:0] buf_q;
    logic [ROWS-1:0][COLS-1:0][DW-1:0] buf_d;

    always_comb begin
        buf_d = buf_q;
        if (load) begin
            buf_d = tile_in;
        end
    end

    // Contents are don't-care until the first load; the reader gates
    // the row output outside the data phase.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign row_data = buf_q[row_sel];

endmodule

// File: rtl/out_drain_ctrl.sv
// Drains one result tile as a single AXI4 INCR burst (AW, ROWS x W, B).
// Ports: tile valid/ready/data/addr in; AXI AW/W/B master; busy/done/err.
module out_drain_ctrl
    import para_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int DW     = DW_DEF,
    parameter int ADDR_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tile_valid,
    output logic                             tile_ready,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0] tile_data,
    input  logic [ADDR_W-1:0]                tile_addr,
    output logic [ADDR_W-1:0]                awaddr,
    output logic [7:0]                       awlen,
    output logic [2:0]                       awsize,
    output logic [1:0]                       awburst,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [COLS*DW-1:0]               wdata,
    output logic [COLS*DW/8-1:0]             wstrb,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic [1:0]                       bresp,
    input  logic                             bvalid,
    output logic                             bready,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    drain_state_t        state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic                err_q, err_d;
    logic                load;
    logic [COLS*DW-1:0]  row_data;

    out_tile_buf #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (DW),
        .RW   (RW)
    ) u_buf (
        .clk      (clk),
        .load     (load),
        .tile_in  (tile_data),
        .row_sel  (row_q),
        .row_data (row_data)
    );

    assign awlen   = 8'(ROWS - 1);
    assign awsize  = 3'($clog2(COLS * DW / 8));
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = '1;
    assign awaddr  = awaddr_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        awaddr_d   = awaddr_q;
        err_d      = err_q;
        load       = 1'b0;
        tile_ready = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        wdata      = '0;
        bready     = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                tile_ready = 1'b1;
                if (tile_valid) begin
                    load     = 1'b1;
                    awaddr_d = tile_addr;
                    err_d    = 1'b0;
                    row_d    = '0;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                wvalid = 1'b1;
                wdata  = row_data;
                wlast  = (row_q == LAST_ROW);
                if (wready) begin
                    // Hold the counter on the last beat so it never wraps.
                    if (row_q == LAST_ROW) begin
                        state_d = RESP;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (bresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            row_q    <= '0;
            awaddr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            awaddr_q <= awaddr_d;
            err_q    <= err_d;
        end
    end

endmodule
